fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
// - Instruction prefetch FIFO between IMEM/PC fetch (stage 1) and the stage-1 pipeline register (decode/regfile read).
// - Decouples fetch from decode stalls: buffers {pc, inst} pairs and presents them in program order.
// - Discards all buffered entries on a pipeline flush (branch mispredict / predictor-driven restart).
// PARAMETERS
// - DEPTH  4   number of entries; power of 2, >= 2
// - XLEN   32  width of pc and inst fields
// - NOP    32'h00000013  value driven on out_inst when no entry is presented (addi x0,x0,0)
// PORTS
// - clk        in   1               clock; all state updates on rising edge
// - rst        in   1               reset, asynchronous, active-low
// - flush      in   1               sync flush; drop all entries (driven by pipeline RST)
// - in_valid   in   1               fetch side has a {pc,inst} pair
// - in_ready   out  1               queue can accept a pair this cycle
// - in_pc      in   XLEN            pc of fetched instruction
// - in_inst    in   XLEN            fetched instruction word
// - out_valid  out  1               head entry valid
// - out_ready  in   1               decode consumes head this cycle
// - out_pc     out  XLEN            head pc (0 when !out_valid)
// - out_inst   out  XLEN            head inst (NOP when !out_valid)
// - count      out  $clog2(DEPTH)+1 number of stored entries
// BEHAVIOUR
// - Storage: DEPTH x {pc,inst} register array; wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits (extra wrap bit).
// - empty = (wr_ptr == rd_ptr); full = (low bits equal, wrap bits differ). Pointers wrap modulo 2*DEPTH.
// - in_ready = !full (combinational, independent of out_ready; no pop-through-full).
// - push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
// - push writes mem[wr_ptr] and increments wr_ptr; pop increments rd_ptr; push+pop in same cycle: both happen, count unchanged.
// - count = wr_ptr - rd_ptr (modulo 2*DEPTH); always 0..DEPTH.
// - Output is first-word-fall-through from storage: out_valid = !empty; out_pc/out_inst = mem[rd_ptr] when valid.
// - Latency input->output: 1 cycle (pair pushed at edge N is visible after edge N).
// - flush: at next edge wr_ptr <= 0, rd_ptr <= 0; same-cycle push and pop are ignored. Storage contents not cleared.
// - flush has priority over push/pop; flush while empty is a no-op apart from pointer reset.
// - in_valid while full: no write, no state change; fetch side must hold the pair.
// - out_ready while empty: no state change.
// - Reset (rst=0, async): wr_ptr=0, rd_ptr=0 -> out_valid=0, in_ready=1, count=0, out_pc=0, out_inst=NOP.
// - Reset deassertion mid-operation: all prior entries lost; first push after release lands in entry 0.
// - No X propagation: out_pc/out_inst never expose unwritten storage (muxed to 0/NOP when empty).
// CONFIGURATION
// - Macro FETCH_QUEUE_BYPASS_EN.
// - Defined: when empty and in_valid & !flush: out_valid=1, out_pc=in_pc, out_inst=in_inst same cycle (0-cycle latency);
//   if out_ready also 1, pair is consumed directly and not written (pointers and count unchanged).
//   If out_ready=0, pair is written normally. Non-empty behaviour identical to undefined case.
// - Undefined: no bypass path; output strictly from storage; 1-cycle minimum latency.
// TESTING
// - Reset: hold rst=0 with in_valid=1 -> out_valid=0, in_ready=1, count=0, out_inst=32'h13, out_pc=0.
// - Fill: out_ready=0, push pc 0x00,0x04,0x08,0x0C (DEPTH=4) -> count=4, in_ready=0; extra push pc 0x10 ignored;
//   then out_ready=1 -> pops 0x00,0x04,0x08,0x0C in order, count 4->0.
// - Simultaneous push/pop at count=2 for 10 cycles with incrementing pc -> count stays 2, order preserved across pointer wrap.
// - Flush: count=3, assert flush with in_valid=1,out_ready=1 -> next cycle count=0, out_valid=0, neither push nor pop took effect;
//   next push pc 0x40 is the head.
// - Async reset mid-stream: drop rst between edges at count=2 -> out_valid=0 immediately, count=0 without clock edge.
// - Bypass (FETCH_QUEUE_BYPASS_EN): empty, in_valid=1,in_pc=0x100,in_inst=0x00A00093,out_ready=1 -> out same cycle, count stays 0;
//   without macro -> out_valid=0 that cycle, pair appears next cycle with count=1.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: in-order prefetch FIFO of {pc, inst} pairs between instruction fetch and decode.
// Optional macro FETCH_QUEUE_BYPASS_EN adds a zero-latency pass-through of the incoming pair while empty.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] NOP = 32'h0000_0013
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [XLEN-1:0]         in_inst,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_inst,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [XLEN-1:0] inst_mem_q [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass_vld;
    logic bypass_take;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign in_ready = !full;
    assign count    = wr_ptr_q - rd_ptr_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Held off during reset so the output stays idle while rst is low.
    assign bypass_vld = empty & in_valid & !flush & rst;
`else
    assign bypass_vld = 1'b0;
`endif
    assign bypass_take = bypass_vld & out_ready;

    assign out_valid = !empty | bypass_vld;
    assign push      = in_valid & in_ready & !flush & !bypass_take;
    assign pop       = !empty & out_ready & !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is never cleared; the output mux below hides stale or unwritten slots.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q[AW-1:0]]   <= in_pc;
            inst_mem_q[wr_ptr_q[AW-1:0]] <= in_inst;
        end
    end

    always_comb begin
        out_pc   = '0;
        out_inst = NOP;
        if (!empty) begin
            out_pc   = pc_mem_q[rd_ptr_q[AW-1:0]];
            out_inst = inst_mem_q[rd_ptr_q[AW-1:0]];
        end else if (bypass_vld) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard-driven bench for fetch_queue (DEPTH=4, XLEN=32), default or FETCH_QUEUE_BYPASS_EN build.
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int tests_run = 0;
    int tests_failed = 0;
    ent_t sb[$];
    logic [68:0] exp_v;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0093;
    endfunction

    // Expected {out_valid, out_pc, out_inst, count, in_ready} from the scoreboard and current inputs.
    function automatic logic [68:0] exp_view();
        logic        v = 1'b0;
        logic [31:0] p = '0;
        logic [31:0] i = NOP;
        if (sb.size() > 0) begin
            v = 1'b1; p = sb[0].pc; i = sb[0].inst;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (in_valid && !flush && rst) begin
            v = 1'b1; p = in_pc; i = in_inst;
        end
`endif
        return {v, p, i, 3'(sb.size()), (sb.size() < DEPTH)};
    endfunction

    task automatic drive(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid = iv; in_pc = pc; in_inst = inst_of(pc); out_ready = ordy; flush = fl;
        #1;
    endtask

    // Advance the scoreboard by the transfer the current inputs imply, then cross one rising edge.
    task automatic tick();
        ent_t tmp;
        logic do_pop, do_push;
        if (flush) begin
            sb.delete();
        end else begin
            do_pop  = out_ready && (sb.size() > 0);
            do_push = in_valid && (sb.size() < DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
            if (sb.size() == 0 && in_valid && out_ready) do_push = 1'b0;
`endif
            if (do_pop) tmp = sb.pop_front();
            if (do_push) sb.push_back({in_pc, inst_of(in_pc)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 2; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 32'h0000_0055, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests_run++; if (out_inst !== 32'h13) begin tests_failed++; $display("FAIL reset_out_inst: got %h expected 00000013", out_inst); end
        tests_run++; if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #3 rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_fill();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'(k * 4), 1'b0, 1'b0);
            exp_v = exp_view(); tests_run++;
            if ({out_valid, out_pc, out_inst, count, in_ready} !== exp_v) begin
                tests_failed++; $display("FAIL fill_push[%0d]: got %h expected %h", k, {out_valid, out_pc, out_inst, count, in_ready}, exp_v);
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tests_run++; if ({count, in_ready} !== {3'd4, 1'b0}) begin tests_failed++; $display("FAIL fill_full: got count=%0d in_ready=%b expected count=4 in_ready=0", count, in_ready); end
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            exp_v = exp_view(); tests_run++;
            if ({out_valid, out_pc, out_inst, count, in_ready} !== exp_v) begin
                tests_failed++; $display("FAIL fill_pop[%0d]: got %h expected %h", k, {out_valid, out_pc, out_inst, count, in_ready}, exp_v);
            end
            tick();
        end
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL fill_drained: got count=%0d expected 0", count); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc = 32'h0000_0200;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, pc, 1'b0, 1'b0); tick(); pc += 4;
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, pc, 1'b1, 1'b0);
            exp_v = exp_view(); tests_run++;
            if ({out_valid, out_pc, out_inst, count, in_ready} !== exp_v || count !== 3'd2) begin
                tests_failed++; $display("FAIL b2b[%0d]: got %h expected %h", k, {out_valid, out_pc, out_inst, count, in_ready}, exp_v);
            end
            tick(); pc += 4;
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            exp_v = exp_view(); tests_run++;
            if ({out_valid, out_pc, out_inst, count, in_ready} !== exp_v) begin
                tests_failed++; $display("FAIL b2b_drain[%0d]: got %h expected %h", k, {out_valid, out_pc, out_inst, count, in_ready}, exp_v);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'(32'h20 + k * 4), 1'b0, 1'b0); tick();
        end
        drive(1'b1, 32'h0000_0030, 1'b1, 1'b1);
        tests_run++; if (count !== 3'd3) begin tests_failed++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tests_run++; if ({out_valid, count, out_inst} !== {1'b0, 3'd0, NOP}) begin
            tests_failed++; $display("FAIL flush_post: got valid=%b count=%0d inst=%h expected valid=0 count=0 inst=%h", out_valid, count, out_inst, NOP);
        end
        drive(1'b1, 32'h0000_0040, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tests_run++; if ({out_valid, out_pc, count} !== {1'b1, 32'h40, 3'd1}) begin
            tests_failed++; $display("FAIL flush_next_head: got valid=%b pc=%h count=%0d expected valid=1 pc=00000040 count=1", out_valid, out_pc, count);
        end
        drain();
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'(32'h60 + k * 4), 1'b0, 1'b0); tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tests_run++; if (count !== 3'd2) begin tests_failed++; $display("FAIL arst_pre_count: got %0d expected 2", count); end
        #1 rst = 1'b0;
        #1;
        tests_run++; if ({out_valid, count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
            tests_failed++; $display("FAIL arst_immediate: got valid=%b count=%0d in_ready=%b expected 0/0/1", out_valid, count, in_ready);
        end
        sb.delete();
        #1 rst = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, 32'h0000_0080, 1'b0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tests_run++; if ({out_valid, out_pc, out_inst, count} !== {1'b1, 32'h80, inst_of(32'h80), 3'd1}) begin
            tests_failed++; $display("FAIL arst_first_push: got valid=%b pc=%h inst=%h count=%0d expected 1/00000080/%h/1", out_valid, out_pc, out_inst, count, inst_of(32'h80));
        end
        drain();
    endtask

    task automatic test_bypass();
        in_valid = 1'b1; in_pc = 32'h0000_0100; in_inst = 32'h00A0_0093; out_ready = 1'b1; flush = 1'b0;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        tests_run++; if ({out_valid, out_pc, out_inst, count} !== {1'b1, 32'h100, 32'h00A0_0093, 3'd0}) begin
            tests_failed++; $display("FAIL bypass_same_cycle: got valid=%b pc=%h inst=%h count=%0d expected 1/00000100/00a00093/0", out_valid, out_pc, out_inst, count);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; #1;
        tests_run++; if ({out_valid, count} !== {1'b0, 3'd0}) begin
            tests_failed++; $display("FAIL bypass_consumed: got valid=%b count=%0d expected 0/0", out_valid, count);
        end
`else
        tests_run++; if ({out_valid, out_inst} !== {1'b0, NOP}) begin
            tests_failed++; $display("FAIL nobypass_same_cycle: got valid=%b inst=%h expected 0/%h", out_valid, out_inst, NOP);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; #1;
        tests_run++; if ({out_valid, out_pc, out_inst, count} !== {1'b1, 32'h100, 32'h00A0_0093, 3'd1}) begin
            tests_failed++; $display("FAIL nobypass_next_cycle: got valid=%b pc=%h inst=%h count=%0d expected 1/00000100/00a00093/1", out_valid, out_pc, out_inst, count);
        end
`endif
        sb.delete();
        for (int k = 0; k < DEPTH + 2; k++) begin
            in_valid = 1'b0; out_ready = 1'b1; #1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0; #1;
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("FAIL bypass_final_count: got %0d expected 0", count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
